// File: rtl/lfsr_prng.sv
// Fibonacci LFSR pseudo-random source with valid/ready output, Steps shifts per transfer and seed load.
// Define LFSR_PERIOD_MON_EN to build the period monitor (period_hit / period_len ports).
module lfsr_prng #(
  parameter int          Width       = 8,
  parameter int          Steps       = 1,
  parameter logic [31:0] DefaultSeed = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] seed,
  input  logic             enable,
  input  logic             out_ready,
  output logic             out_valid,
`ifdef LFSR_PERIOD_MON_EN
  output logic             period_hit,
  output logic [Width-1:0] period_len,
`endif
  output logic [Width-1:0] data_out
);

  // Reject unsupported configurations at elaboration time.
  if (!(Width == 3 || Width == 4 || Width == 5 || Width == 6 ||
        Width == 7 || Width == 8 || Width == 16 || Width == 32)) begin : g_bad_width
    $error("lfsr_prng: Width %0d has no maximal-length tap set", Width);
  end
  if (Steps < 1 || Steps > Width) begin : g_bad_steps
    $error("lfsr_prng: Steps %0d outside 1..Width", Steps);
  end
  if ((64'(DefaultSeed) >> Width) != 64'd0 || DefaultSeed == 32'd0) begin : g_bad_seed
    $error("lfsr_prng: DefaultSeed must be nonzero and fit in Width bits");
  end

  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      3:       return 32'h0000_0005;
      4:       return 32'h0000_0009;
      5:       return 32'h0000_0005;
      6:       return 32'h0000_0003;
      7:       return 32'h0000_0003;
      8:       return 32'h0000_001D;
      16:      return 32'h0000_002D;
      32:      return 32'h0040_0007;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]      TapMaskFull = tap_mask(Width);
  localparam logic [Width-1:0] TapMask     = TapMaskFull[Width-1:0];
  localparam logic [Width-1:0] ResetSeed   = DefaultSeed[Width-1:0];
  localparam logic [Width-1:0] OneValue    = Width'(1);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             fsm;
  logic [Width-1:0] lfsr;
  logic [Width-1:0] next_state;
  logic [Width-1:0] seed_guarded;
  logic             fire;

  function automatic logic [Width-1:0] lfsr_shift(input logic [Width-1:0] s);
    return {^(s & TapMask), s[Width-1:1]};
  endfunction

  // Steps single shifts unrolled into one combinational advance.
  function automatic logic [Width-1:0] lfsr_advance(input logic [Width-1:0] s);
    logic [Width-1:0] t;
    t = s;
    for (int k = 0; k < Steps; k++) begin
      t = lfsr_shift(t);
    end
    return t;
  endfunction

  assign next_state   = lfsr_advance(lfsr);
  assign seed_guarded = (seed == '0) ? OneValue : seed;
  assign fire         = out_valid & out_ready;
  assign data_out     = lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= ResetSeed;
      fsm       <= IDLE;
      out_valid <= 1'b0;
    end else if (load) begin
      lfsr      <= seed_guarded;
      fsm       <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (enable) begin
            fsm       <= RUN;
            out_valid <= 1'b1;
          end
        end
        RUN: begin
          if (fire) begin
            lfsr <= next_state;
            if (!enable) begin
              fsm       <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LFSR_PERIOD_MON_EN
  logic [Width-1:0] seed_ref;
  logic [Width-1:0] fire_cnt;
  logic [Width-1:0] cnt_inc;

  assign cnt_inc = (fire_cnt == '1) ? fire_cnt : fire_cnt + Width'(1);

  // A period closes when a fire lands the state back on the last loaded seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_ref   <= ResetSeed;
      fire_cnt   <= '0;
      period_hit <= 1'b0;
      period_len <= '0;
    end else if (load) begin
      seed_ref   <= seed_guarded;
      fire_cnt   <= '0;
      period_hit <= 1'b0;
      period_len <= '0;
    end else begin
      period_hit <= 1'b0;
      if (fire) begin
        if (next_state == seed_ref) begin
          period_hit <= 1'b1;
          period_len <= cnt_inc;
          fire_cnt   <= '0;
        end else begin
          fire_cnt <= cnt_inc;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: three configurations (W4/S1, W8/S1, W16/S3) checked every cycle
// against a tap-list behavioural model, plus literal expectations from hand-stepped sequences.
module tb_lfsr_prng;

  localparam int WIDTHS[3] = '{4, 8, 16};
  localparam int STEPS[3]  = '{1, 1, 3};

  typedef struct {
    logic [31:0] state;
    logic        valid;
    logic [31:0] seed_ref;
    logic [31:0] cnt;
    logic        hit;
    logic [31:0] len;
  } model_t;

  logic        clk;
  logic [2:0]  reset_s;
  logic [2:0]  load_s;
  logic [2:0]  enable_s;
  logic [2:0]  ready_s;
  logic [31:0] seed_s [3];

  logic        valid0, valid1, valid2;
  logic [3:0]  data0;
  logic [7:0]  data1;
  logic [15:0] data2;
`ifdef LFSR_PERIOD_MON_EN
  logic        hit0, hit1, hit2;
  logic [3:0]  len0;
  logic [7:0]  len1;
  logic [15:0] len2;
`endif

  model_t m [3];
  bit     cmp_on;
  int     checks;
  int     errors;

  lfsr_prng #(.Width(4), .Steps(1), .DefaultSeed(32'd1)) u_dut_w4 (
    .clk(clk), .reset(reset_s[0]), .load(load_s[0]), .seed(seed_s[0][3:0]),
    .enable(enable_s[0]), .out_ready(ready_s[0]), .out_valid(valid0),
`ifdef LFSR_PERIOD_MON_EN
    .period_hit(hit0), .period_len(len0),
`endif
    .data_out(data0)
  );

  lfsr_prng #(.Width(8), .Steps(1), .DefaultSeed(32'd1)) u_dut_w8 (
    .clk(clk), .reset(reset_s[1]), .load(load_s[1]), .seed(seed_s[1][7:0]),
    .enable(enable_s[1]), .out_ready(ready_s[1]), .out_valid(valid1),
`ifdef LFSR_PERIOD_MON_EN
    .period_hit(hit1), .period_len(len1),
`endif
    .data_out(data1)
  );

  lfsr_prng #(.Width(16), .Steps(3), .DefaultSeed(32'd1)) u_dut_w16 (
    .clk(clk), .reset(reset_s[2]), .load(load_s[2]), .seed(seed_s[2][15:0]),
    .enable(enable_s[2]), .out_ready(ready_s[2]), .out_valid(valid2),
`ifdef LFSR_PERIOD_MON_EN
    .period_hit(hit2), .period_len(len2),
`endif
    .data_out(data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shift: feedback is the parity of the listed tap bits, shifted in at the top.
  function automatic logic [31:0] ref_shift(input logic [31:0] s, input int w);
    int   taps[4];
    logic fb;
    case (w)
      4:       taps = '{3, 0, -1, -1};
      8:       taps = '{4, 3, 2, 0};
      default: taps = '{5, 3, 2, 0};
    endcase
    fb = 1'b0;
    foreach (taps[k]) if (taps[k] >= 0) fb = fb ^ s[taps[k]];
    return (s >> 1) | (32'(fb) << (w - 1));
  endfunction

  function automatic model_t model_next(input model_t cur, input int i, input logic rst,
                                        input logic ld, input logic [31:0] sd,
                                        input logic en, input logic rdy);
    model_t      n;
    logic [31:0] maxv;
    logic [31:0] inc;
    n    = cur;
    maxv = (32'd1 << WIDTHS[i]) - 32'd1;
    inc  = (cur.cnt == maxv) ? maxv : cur.cnt + 32'd1;
    n.hit = 1'b0;
    if (rst) begin
      n.state = 32'd1; n.valid = 1'b0; n.seed_ref = 32'd1; n.cnt = 0; n.len = 0;
    end else if (ld) begin
      n.state    = ((sd & maxv) == 0) ? 32'd1 : (sd & maxv);
      n.valid    = 1'b0;
      n.seed_ref = n.state;
      n.cnt      = 0;
      n.len      = 0;
    end else if (cur.valid && rdy) begin
      for (int k = 0; k < STEPS[i]; k++) n.state = ref_shift(n.state, WIDTHS[i]);
      n.valid = en;
      if (n.state == cur.seed_ref) begin
        n.hit = 1'b1; n.len = inc; n.cnt = 0;
      end else begin
        n.cnt = inc;
      end
    end else if (!cur.valid && en) begin
      n.valid = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m[i] <= model_next(m[i], i, reset_s[i], load_s[i], seed_s[i], enable_s[i], ready_s[i]);
    end
  end

  function automatic logic [31:0] get_data(input int i);
    case (i)
      0:       return 32'(data0);
      1:       return 32'(data1);
      default: return 32'(data2);
    endcase
  endfunction

  function automatic logic [31:0] get_valid(input int i);
    case (i)
      0:       return 32'(valid0);
      1:       return 32'(valid1);
      default: return 32'(valid2);
    endcase
  endfunction

`ifdef LFSR_PERIOD_MON_EN
  function automatic logic [31:0] get_hit(input int i);
    case (i)
      0:       return 32'(hit0);
      1:       return 32'(hit1);
      default: return 32'(hit2);
    endcase
  endfunction

  function automatic logic [31:0] get_len(input int i);
    case (i)
      0:       return 32'(len0);
      1:       return 32'(len1);
      default: return 32'(len2);
    endcase
  endfunction
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic rst, input logic ld, input logic [31:0] sd,
                               input logic en, input logic rdy);
    reset_s[i]  = rst;
    load_s[i]   = ld;
    seed_s[i]   = sd;
    enable_s[i] = en;
    ready_s[i]  = rdy;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model comparison on every cycle once the first reset edge has passed.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("dut%0d.out_valid", i), get_valid(i), 32'(m[i].valid));
        checkOutput($sformatf("dut%0d.data_out", i), get_data(i), m[i].state);
`ifdef LFSR_PERIOD_MON_EN
        checkOutput($sformatf("dut%0d.period_hit", i), get_hit(i), 32'(m[i].hit));
        checkOutput($sformatf("dut%0d.period_len", i), get_len(i), m[i].len);
`endif
      end
    end
  end

  initial begin
    logic [3:0] exp_seq [6];
    int         zero_seen;
    int         first_return;

    exp_seq      = '{4'h1, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7};
    checks       = 0;
    errors       = 0;
    cmp_on       = 1'b0;
    zero_seen    = 0;
    first_return = 0;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

    tick();
    cmp_on = 1'b1;
    tick();
    checkOutput("reset.valid_w4", 32'(valid0), 32'd0);
    checkOutput("reset.data_w4", 32'(data0), 32'h1);
    checkOutput("reset.data_w16", 32'(data2), 32'h0001);
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    $display("[TB] W4 Steps=1 sequence from seed 0001");
    applyStimulus(0, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("w4.first_valid", 32'(valid0), 32'd1);
    checkOutput("w4.seq0", 32'(data0), 32'(exp_seq[0]));
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k <= 5) checkOutput($sformatf("w4.seq%0d", k), 32'(data0), 32'(exp_seq[k]));
`ifdef LFSR_PERIOD_MON_EN
      if (k == 14) checkOutput("w4.no_early_hit", 32'(hit0), 32'd0);
      if (k == 15) begin
        checkOutput("w4.period_hit", 32'(hit0), 32'd1);
        checkOutput("w4.period_len", 32'(len0), 32'd15);
      end
`endif
    end
    checkOutput("w4.wrap_to_seed", 32'(data0), 32'h1);

    $display("[TB] W4 backpressure");
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("w4.hold_data", 32'(data0), 32'h1);
      checkOutput("w4.hold_valid", 32'(valid0), 32'd1);
    end
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("w4.last_fire_data", 32'(data0), 32'h8);
    checkOutput("w4.last_fire_valid", 32'(valid0), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("w4.idle_retained", 32'(data0), 32'h8);

    $display("[TB] W4 load in the same cycle as fire");
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("w4.rerun_valid", 32'(valid0), 32'd1);
    applyStimulus(0, 1'b0, 1'b1, 32'h5, 1'b1, 1'b1);
    tick();
    checkOutput("w4.load_data", 32'(data0), 32'h5);
    checkOutput("w4.load_valid", 32'(valid0), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("w4.after_load_data", 32'(data0), 32'h5);
    checkOutput("w4.after_load_valid", 32'(valid0), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] W8 zero seed and full period");
    applyStimulus(1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("w8.zero_seed_guard", 32'(data1), 32'h01);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("w8.first_valid", 32'(valid1), 32'd1);
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (data1 == 8'h00) zero_seen++;
      if (data1 == 8'h01 && first_return == 0) first_return = k;
      if (k == 1) checkOutput("w8.step1", 32'(data1), 32'h80);
      if (k == 2) checkOutput("w8.step2", 32'(data1), 32'h40);
`ifdef LFSR_PERIOD_MON_EN
      if (k == 255) begin
        checkOutput("w8.period_hit", 32'(hit1), 32'd1);
        checkOutput("w8.period_len", 32'(len1), 32'd255);
      end
`endif
    end
    checkOutput("w8.no_zero_state", 32'(zero_seen), 32'd0);
    checkOutput("w8.period", 32'(first_return), 32'd255);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] W16 Steps=3 and reset mid-transfer");
    applyStimulus(2, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("w16.first_data", 32'(data2), 32'h0001);
    tick();
    checkOutput("w16.three_steps", 32'(data2), 32'h2000);
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("w16.held", 32'(data2), 32'h2000);
    applyStimulus(2, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("w16.reset_valid", 32'(valid2), 32'd0);
    checkOutput("w16.reset_data", 32'(data2), 32'h0001);
`ifdef LFSR_PERIOD_MON_EN
    checkOutput("w16.reset_hit", 32'(hit2), 32'd0);
`endif
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] randomized traffic on all instances");
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        applyStimulus(i,
                      ($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 1) == 1));
      end
      tick();
    end
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
